mby_msh_row_wr_inj: RTL
=======================

Name: mby_msh_row_wr_inj

Overview:
- Injection stage that feeds write requests into one west-boundary eastbound row write port of the mesh (mby_msh i_west_eb_wr_ifs[row]).
- Accepts client writes on a valid/ready port and buffers them in a FIFO.
- Issues them to the mesh under credit-based flow control; the mesh returns one credit per consumed write.
- Reports credit-protocol errors and occupancy for debug.

Parameters:
ADDR_W, 20, write address width
DATA_W, 64, write data width
ID_W, 8, request tag width
FIFO_DEPTH, 8, request buffer entries (power of 2, >=2)
NUM_CREDITS, 4, mesh-side credits granted at reset (1..15)

Ports:
mclk  in  1  mesh clock
i_reset  in  1  synchronous active-high reset
i_req_valid  in  1  client write request valid
o_req_ready  out  1  client request accepted when valid&ready
i_req_addr  in  ADDR_W  client write address
i_req_data  in  DATA_W  client write data
i_req_id  in  ID_W  client request tag
o_wr_valid  out  1  one-cycle write issue to mesh row port
o_wr_addr  out  ADDR_W  issued address
o_wr_data  out  DATA_W  issued data
o_wr_id  out  ID_W  issued tag
i_wr_credit  in  1  one-cycle credit return pulse from mesh
o_credit_cnt  out  $clog2(NUM_CREDITS+1)  credits currently held
o_fifo_cnt  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
o_err_credit_ovf  out  1  sticky: credit returned while count==NUM_CREDITS

Behaviour:
- Interface: one clock mclk; reset i_reset is synchronous, active-high.
- Reset values:
  - o_req_ready=0 during reset, 1 from the first cycle after reset deasserts.
  - o_wr_valid=0; o_wr_addr/data/id=0.
  - o_credit_cnt=NUM_CREDITS; o_fifo_cnt=0; o_err_credit_ovf=0.
  - FIFO pointers cleared.
- Reset mid-operation: FIFO contents are discarded and credits reload to NUM_CREDITS; no write issues in the reset cycle or the cycle after.
- Accept:
  - o_req_ready = !full; it does not depend on i_req_valid.
  - Push occurs on i_req_valid & o_req_ready.
- Issue condition: FIFO non-empty & o_credit_cnt>0.
- Issue action, at the next mclk edge:
  - o_wr_valid=1 for exactly one cycle;
  - o_wr_addr/data/id take the FIFO head;
  - the head is popped;
  - credit_cnt is decremented.
  - At most one issue per cycle; back-to-back issues are allowed.
- Latency: a request accepted at edge N into an empty FIFO with credits available appears on o_wr_valid at edge N+1 (1-cycle minimum latency). There is no bypass.
- Ordering: strict FIFO order; no reordering or dropping.
- Payload hold: o_wr_addr/data/id hold their last value while o_wr_valid=0.
- Credit counter:
  - issue & !credit → cnt-1;
  - credit & !issue → cnt+1;
  - issue & credit simultaneously → unchanged.
  - Credit return at cnt==NUM_CREDITS with no simultaneous issue: cnt stays saturated and o_err_credit_ovf is set (sticky until reset).
  - cnt==0: no issue; the FIFO holds its contents.
- FIFO boundaries:
  - Push and pop in the same cycle: occupancy unchanged.
  - When full, ready=0, so no push can coincide with a pop that cycle. Ready rises the cycle after a pop frees an entry.
  - Read/write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer MSB.
- o_fifo_cnt and o_credit_cnt are registered and reflect state after each edge.

Test Plan:
- Reset, then a single request (addr=0x00012, data=0xDEADBEEF, id=0x05) → o_wr_valid exactly 1 cycle after acceptance with the same payload; o_credit_cnt goes 4→3.
- Push 6 requests back-to-back with no credit returns → exactly 4 issues in consecutive cycles; o_credit_cnt=0, o_fifo_cnt=2. Return 2 credits → remaining 2 issue in order; cnt ends 0.
- Hold credits at 0 and push 8 requests → o_fifo_cnt=8, o_req_ready=0, 9th request stalls. One credit returned → one issue, then ready=1 the following cycle.
- Simultaneous i_wr_credit and issue at cnt=2 → cnt stays 2. Credit pulse at cnt=4 with FIFO empty → cnt stays 4, o_err_credit_ovf=1 and stays 1.
- Assert i_reset for 1 cycle with 3 queued and cnt=1 → no issue that cycle or the next; o_fifo_cnt=0, o_credit_cnt=4, o_err_credit_ovf=0.
- Random valid/credit traffic over 10k cycles with a scoreboard → in-order payload match, no issue at cnt=0, and issued minus returned credits never exceeds 4.

Source files
------------

// File: rtl/mby_msh_row_wr_inj.sv
// ----------------------------------------------------------------------------
// mby_msh_row_wr_inj
//
// Injection stage for one west-boundary eastbound row write port of the mesh.
// Client writes arrive on a valid/ready port and are buffered in a FIFO. They
// are issued to the mesh one per cycle while credits are held. The mesh
// returns one credit per consumed write.
//
// Ports:
//   mclk              mesh clock
//   i_reset           synchronous active-high reset
//   i_req_valid       client write request valid
//   o_req_ready       client request accepted when valid & ready (= !full)
//   i_req_addr/data/id client write payload
//   o_wr_valid        one-cycle write issue pulse to the mesh row port
//   o_wr_addr/data/id issued payload, held while o_wr_valid is low
//   i_wr_credit       one-cycle credit return pulse from the mesh
//   o_credit_cnt      credits currently held
//   o_fifo_cnt        FIFO occupancy
//   o_err_credit_ovf  sticky: credit returned while already holding all credits
// ----------------------------------------------------------------------------
module mby_msh_row_wr_inj #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 64,
   parameter int ID_W        = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int NUM_CREDITS = 4
) (
   input  logic                               mclk,
   input  logic                               i_reset,
   input  logic                               i_req_valid,
   output logic                               o_req_ready,
   input  logic [ADDR_W-1:0]                  i_req_addr,
   input  logic [DATA_W-1:0]                  i_req_data,
   input  logic [ID_W-1:0]                    i_req_id,
   output logic                               o_wr_valid,
   output logic [ADDR_W-1:0]                  o_wr_addr,
   output logic [DATA_W-1:0]                  o_wr_data,
   output logic [ID_W-1:0]                    o_wr_id,
   input  logic                               i_wr_credit,
   output logic [$clog2(NUM_CREDITS+1)-1:0]   o_credit_cnt,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_cnt,
   output logic                               o_err_credit_ovf
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(NUM_CREDITS+1);
   localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
   localparam int ENT_W  = ADDR_W + DATA_W + ID_W;
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(NUM_CREDITS);

   // Pointers carry one extra MSB so that full and empty can be told apart.
   function automatic logic ptr_full(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
      return (wr[PTR_W] != rd[PTR_W]) && (wr[PTR_W-1:0] == rd[PTR_W-1:0]);
   endfunction

   function automatic logic ptr_empty(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
      return (wr == rd);
   endfunction

   logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_r;
   logic [PTR_W:0]     rd_ptr_r;
   logic [PTR_W:0]     wr_ptr_nxt_s;
   logic [PTR_W:0]     rd_ptr_nxt_s;
   logic [FCNT_W-1:0]  fifo_cnt_r;
   logic [CNT_W-1:0]   credit_cnt_r;
   logic [CNT_W-1:0]   credit_cnt_nxt_s;
   logic               credit_ovf_s;
   logic               err_ovf_r;
   logic               ready_r;
   logic               wr_valid_r;
   logic [ADDR_W-1:0]  wr_addr_r;
   logic [DATA_W-1:0]  wr_data_r;
   logic [ID_W-1:0]    wr_id_r;
   logic               push_s;
   logic               issue_s;
   logic               empty_s;
   logic               full_s;
   logic               full_nxt_s;
   logic [ENT_W-1:0]   head_s;

   assign empty_s = ptr_empty(wr_ptr_r, rd_ptr_r);
   assign full_s  = ptr_full(wr_ptr_r, rd_ptr_r);
   assign push_s  = i_req_valid && ready_r && !full_s;
   // Issue decision uses only registered state, so there is no input-to-output bypass.
   assign issue_s = !empty_s && (credit_cnt_r != '0);
   assign head_s  = mem_r[rd_ptr_r[PTR_W-1:0]];

   // Next FIFO pointers from push/pop of this cycle.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + (PTR_W+1)'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (issue_s) begin
         rd_ptr_nxt_s = rd_ptr_r + (PTR_W+1)'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      full_nxt_s = ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
   end

   // Next credit count; a return while saturated is flagged instead of counted.
   always_comb begin
      credit_cnt_nxt_s = credit_cnt_r;
      credit_ovf_s     = 1'b0;
      case ({issue_s, i_wr_credit})
         2'b10: begin
            credit_cnt_nxt_s = credit_cnt_r - CNT_W'(1);
         end
         2'b01: begin
            if (credit_cnt_r == CREDIT_MAX) begin
               credit_ovf_s = 1'b1;
            end else begin
               credit_cnt_nxt_s = credit_cnt_r + CNT_W'(1);
            end
         end
         default: begin
            credit_cnt_nxt_s = credit_cnt_r;
         end
      endcase
   end

   // FIFO storage write; contents need no reset since the pointers gate them.
   always_ff @(posedge mclk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= {i_req_addr, i_req_data, i_req_id};
      end
   end

   // Control state: pointers, occupancy, credits, ready and error flag.
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         fifo_cnt_r   <= '0;
         credit_cnt_r <= CREDIT_MAX;
         err_ovf_r    <= 1'b0;
         ready_r      <= 1'b0;
      end else begin
         wr_ptr_r     <= wr_ptr_nxt_s;
         rd_ptr_r     <= rd_ptr_nxt_s;
         fifo_cnt_r   <= FCNT_W'(wr_ptr_nxt_s - rd_ptr_nxt_s);
         credit_cnt_r <= credit_cnt_nxt_s;
         err_ovf_r    <= err_ovf_r | credit_ovf_s;
         ready_r      <= !full_nxt_s;
      end
   end

   // Issue register: one-cycle valid pulse, payload held between issues.
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         wr_valid_r <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= '0;
         wr_id_r    <= '0;
      end else begin
         wr_valid_r <= issue_s;
         if (issue_s) begin
            {wr_addr_r, wr_data_r, wr_id_r} <= head_s;
         end
      end
   end

   assign o_req_ready      = ready_r;
   assign o_wr_valid       = wr_valid_r;
   assign o_wr_addr        = wr_addr_r;
   assign o_wr_data        = wr_data_r;
   assign o_wr_id          = wr_id_r;
   assign o_credit_cnt     = credit_cnt_r;
   assign o_fifo_cnt       = fifo_cnt_r;
   assign o_err_credit_ovf = err_ovf_r;

endmodule
